// File: rtl/tmr_mon_pkg.sv
// Shared types and default sizing for the TMR output monitor.
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    FAILED   = 2'd2
  } health_t;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned ERR_THRESH_DEF = 3;
  localparam int unsigned CLEAN_RUN_DEF  = 8;
  localparam int unsigned CNT_W_DEF      = 8;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH_DEF) + 1;

  // Pointer width for a given depth: one extra wrap bit distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tmr_output_monitor_if.sv
// Voter-side sample inputs and consumer-side stream/status outputs of the monitor.
interface tmr_output_monitor_if
  import tmr_mon_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic [DATA_W-1:0] vote_data;
  logic              vote_valid;
  logic              tmr_error;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              fifo_full;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  ovf_count;
  logic [1:0]        health;
  logic              alarm;

  modport master (
    output vote_data, vote_valid, tmr_error, out_ready,
    input  out_data, out_valid, fifo_full, err_count, ovf_count, health, alarm
  );

  modport slave (
    input  vote_data, vote_valid, tmr_error, out_ready,
    output out_data, out_valid, fifo_full, err_count, ovf_count, health, alarm
  );

endinterface

// File: rtl/tmr_mon_fifo.sv
// First-word-fall-through FIFO; head is visible on rdata_o while empty_o is low.
module tmr_mon_fifo
  import tmr_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PW   = ptr_width(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Full when the wrap bits differ and the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/tmr_output_monitor.sv
// Buffers clean voted words, counts voter errors/overflows and tracks system health.
// Optional TMR_MON_RECOVER_EN: a run of CLEAN_RUN clean samples returns DEGRADED to NORMAL.
module tmr_output_monitor
  import tmr_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned ERR_THRESH = ERR_THRESH_DEF,
  parameter int unsigned CLEAN_RUN  = CLEAN_RUN_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  tmr_output_monitor_if.slave bus
);

  localparam int unsigned     CE_W    = $clog2(ERR_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (ERR_THRESH < 1) begin : g_bad_thresh
    $error("ERR_THRESH must be at least 1");
  end
  if (CLEAN_RUN < 1) begin : g_bad_clean_run
    $error("CLEAN_RUN must be at least 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  health_t           health_q, health_d;
  logic              alarm_q;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [CE_W-1:0]   cerr_q, cerr_d;
  logic              sample_err, sample_clean;
  logic              push, pop, full, empty;
  logic [DATA_W-1:0] head;

`ifdef TMR_MON_RECOVER_EN
  localparam int unsigned CR_W = $clog2(CLEAN_RUN + 1);
  logic [CR_W-1:0] crun_q, crun_d;
`endif

  assign sample_err   = bus.vote_valid &  bus.tmr_error;
  assign sample_clean = bus.vote_valid & ~bus.tmr_error;

  // Full is the registered flag, so a pop on the same edge never makes room.
  assign push = sample_clean & ~full & (health_q != FAILED);
  assign pop  = bus.out_ready & ~empty;

  tmr_mon_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.vote_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      health_q  <= NORMAL;
      alarm_q   <= 1'b0;
      err_cnt_q <= '0;
      ovf_cnt_q <= '0;
      cerr_q    <= '0;
`ifdef TMR_MON_RECOVER_EN
      crun_q    <= '0;
`endif
    end else begin
      health_q  <= health_d;
      alarm_q   <= (health_d == FAILED);
      err_cnt_q <= err_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      cerr_q    <= cerr_d;
`ifdef TMR_MON_RECOVER_EN
      crun_q    <= crun_d;
`endif
    end
  end

  always_comb begin
    health_d  = health_q;
    err_cnt_d = err_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    cerr_d    = cerr_q;
`ifdef TMR_MON_RECOVER_EN
    crun_d    = crun_q;
`endif

    if (sample_err) begin
      if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (cerr_q != CE_W'(ERR_THRESH)) cerr_d = cerr_q + CE_W'(1);
`ifdef TMR_MON_RECOVER_EN
      crun_d = '0;
`endif
    end else if (sample_clean) begin
      cerr_d = '0;
      if (full && (ovf_cnt_q != CNT_MAX)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
`ifdef TMR_MON_RECOVER_EN
      if (crun_q != CR_W'(CLEAN_RUN)) crun_d = crun_q + CR_W'(1);
`endif
    end

    // The error that leaves NORMAL also counts toward the threshold.
    unique case (health_q)
      NORMAL: begin
        if (sample_err) health_d = (cerr_d >= CE_W'(ERR_THRESH)) ? FAILED : DEGRADED;
      end
      DEGRADED: begin
        if (sample_err && (cerr_d >= CE_W'(ERR_THRESH))) begin
          health_d = FAILED;
        end
`ifdef TMR_MON_RECOVER_EN
        else if (sample_clean && (crun_d >= CR_W'(CLEAN_RUN))) begin
          health_d = NORMAL;
          crun_d   = '0;
        end
`endif
      end
      FAILED:  health_d = FAILED;
      default: health_d = NORMAL;
    endcase
  end

  assign bus.out_data  = head;
  assign bus.out_valid = ~empty;
  assign bus.fifo_full = full;
  assign bus.err_count = err_cnt_q;
  assign bus.ovf_count = ovf_cnt_q;
  assign bus.health    = health_q;
  assign bus.alarm     = alarm_q;

endmodule
